// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter feeding four memory requesters into a DDR2 address/write-data FIFO pair.
// Define VIDEO_PRIORITY_EN to give requester 0 (video) fixed priority over the round-robin.
module mem_req_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req_valid,
  output logic [3:0]    req_ready,
  input  logic [3:0]    req_rnw,
  input  logic [123:0]  req_addr,
  input  logic [1023:0] req_wdata,
  input  logic [127:0]  req_wmask,
  output logic          af_wr_en,
  output logic [30:0]   af_addr_din,
  output logic [2:0]    af_cmd_din,
  input  logic          af_full,
  output logic          wdf_wr_en,
  output logic [127:0]  wdf_din,
  output logic [15:0]   wdf_mask_din,
  input  logic          wdf_full,
  input  logic          rdf_valid,
  input  logic [127:0]  rdf_dout,
  output logic [3:0]    resp_valid,
  output logic [127:0]  resp_data
);

  typedef enum logic [0:0] {StIdle, StWr2} state_e;

  state_e       state_q, state_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]   tag_mem_q [8];
  logic [2:0]   tag_wr_ptr_q, tag_wr_ptr_d;
  logic [2:0]   tag_rd_ptr_q, tag_rd_ptr_d;
  logic [3:0]   tag_cnt_q, tag_cnt_d;
  logic         beat_q, beat_d;
  logic [127:0] beat1_q, beat1_d;
  logic [15:0]  mask1_q, mask1_d;

  logic         tag_full, tag_empty, tag_push, tag_pop;
  logic [3:0]   elig;
  logic         grant_vld;
  logic [1:0]   grant_idx;
  logic [1:0]   idx;

  assign tag_full  = (tag_cnt_q == 4'd8);
  assign tag_empty = (tag_cnt_q == 4'd0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = req_valid[i] & ~af_full & (req_rnw[i] ? ~tag_full : ~wdf_full);
    end
  end

  // Search starts at the requester after the previous grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
`ifdef VIDEO_PRIORITY_EN
    if (elig[0]) begin
      grant_vld = 1'b1;
      grant_idx = 2'd0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    beat1_d      = beat1_q;
    mask1_d      = mask1_q;
    beat_d       = beat_q;
    tag_push     = 1'b0;
    tag_pop      = 1'b0;
    req_ready    = '0;
    af_wr_en     = 1'b0;
    af_addr_din  = '0;
    af_cmd_din   = 3'b000;
    wdf_wr_en    = 1'b0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    resp_valid   = '0;
    resp_data    = rdf_dout;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          af_wr_en             = 1'b1;
          af_addr_din          = req_addr[31*grant_idx +: 31];
`ifdef VIDEO_PRIORITY_EN
          if (grant_idx != 2'd0) rr_ptr_d = grant_idx + 2'd1;
`else
          rr_ptr_d = grant_idx + 2'd1;
`endif
          if (req_rnw[grant_idx]) begin
            af_cmd_din = 3'b001;
            tag_push   = 1'b1;
          end else begin
            wdf_wr_en    = 1'b1;
            wdf_din      = req_wdata[256*grant_idx +: 128];
            wdf_mask_din = req_wmask[32*grant_idx +: 16];
            beat1_d      = req_wdata[256*grant_idx + 128 +: 128];
            mask1_d      = req_wmask[32*grant_idx + 16 +: 16];
            state_d      = StWr2;
          end
        end
      end
      StWr2: begin
        if (!wdf_full) begin
          wdf_wr_en    = 1'b1;
          wdf_din      = beat1_q;
          wdf_mask_din = mask1_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A beat with no outstanding tag is dropped without touching FIFO state.
    if (rdf_valid && !tag_empty) begin
      resp_valid[tag_mem_q[tag_rd_ptr_q]] = 1'b1;
      beat_d  = ~beat_q;
      tag_pop = beat_q;
    end

    if (!rst_n) begin
      req_ready    = '0;
      af_wr_en     = 1'b0;
      af_addr_din  = '0;
      af_cmd_din   = 3'b000;
      wdf_wr_en    = 1'b0;
      wdf_din      = '0;
      wdf_mask_din = '0;
      resp_valid   = '0;
      resp_data    = '0;
    end
  end

  always_comb begin
    tag_wr_ptr_d = tag_push ? tag_wr_ptr_q + 3'd1 : tag_wr_ptr_q;
    tag_rd_ptr_d = tag_pop  ? tag_rd_ptr_q + 3'd1 : tag_rd_ptr_q;
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 4'd1;
      2'b01:   tag_cnt_d = tag_cnt_q - 4'd1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= 2'd0;
      tag_wr_ptr_q <= 3'd0;
      tag_rd_ptr_q <= 3'd0;
      tag_cnt_q    <= 4'd0;
      beat_q       <= 1'b0;
      beat1_q      <= '0;
      mask1_q      <= '0;
      for (int i = 0; i < 8; i++) tag_mem_q[i] <= 2'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
      beat_q       <= beat_d;
      beat1_q      <= beat1_d;
      mask1_q      <= mask1_d;
      if (tag_push) tag_mem_q[tag_wr_ptr_q] <= grant_idx;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; expected values are hand-derived per step.
// Honours VIDEO_PRIORITY_EN for the round-robin expectations.
module tb_mem_req_arbiter;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid, req_ready, req_rnw;
  logic [123:0]  req_addr;
  logic [1023:0] req_wdata;
  logic [127:0]  req_wmask;
  logic          af_wr_en, af_full;
  logic [30:0]   af_addr_din;
  logic [2:0]    af_cmd_din;
  logic          wdf_wr_en, wdf_full;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;
  logic          rdf_valid;
  logic [127:0]  rdf_dout;
  logic [3:0]    resp_valid;
  logic [127:0]  resp_data;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] B0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] B1 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [127:0] B2 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] B3 = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;
  localparam logic [127:0] B4 = 128'h1357_9BDF_1357_9BDF_1357_9BDF_1357_9BDF;
  localparam logic [127:0] B5 = 128'h2468_ACE0_2468_ACE0_2468_ACE0_2468_ACE0;
  localparam logic [127:0] D0 = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [127:0] D1 = 128'h0BAD_F00D_1111_2222_3333_4444_5555_6666;

  logic [3:0] rr_exp [5];

  mem_req_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rnw      (req_rnw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wmask    (req_wmask),
    .af_wr_en     (af_wr_en),
    .af_addr_din  (af_addr_din),
    .af_cmd_din   (af_cmd_din),
    .af_full      (af_full),
    .wdf_wr_en    (wdf_wr_en),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din),
    .wdf_full     (wdf_full),
    .rdf_valid    (rdf_valid),
    .rdf_dout     (rdf_dout),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req_valid = '0;
    req_rnw   = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    af_full   = 1'b0;
    wdf_full  = 1'b0;
    rdf_valid = 1'b0;
    rdf_dout  = '0;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [30:0] a,
                         input logic [255:0] d, input logic [31:0] m);
    req_valid[i]           = 1'b1;
    req_rnw[i]             = rnw;
    req_addr[31*i +: 31]   = a;
    req_wdata[256*i +: 256] = d;
    req_wmask[32*i +: 32]  = m;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef VIDEO_PRIORITY_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    // Reset with live inputs: every output must stay quiet.
    clr();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 31'h10 + 31'(i), '0, '0);
    rdf_valid = 1'b1;
    rdf_dout  = D0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_af_wr_en", af_wr_en, 0);
    chk("rst_af_addr", af_addr_din, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    @(negedge clk);
    clr();
    rst_n = 1'b1;

    // Single icache read, two returned beats, then a stray beat on an empty FIFO.
    cyc();
    set_req(2, 1'b1, 31'h100, '0, '0);
    #1;
    chk("rd_ready", req_ready, 4'b0100);
    chk("rd_af_wr_en", af_wr_en, 1);
    chk("rd_cmd", af_cmd_din, 3'b001);
    chk("rd_addr", af_addr_din, 31'h100);
    cyc();
    clr();
    rdf_valid = 1'b1;
    rdf_dout  = D0;
    #1;
    chk("rd_beat0_valid", resp_valid, 4'b0100);
    chk("rd_beat0_data", resp_data, D0);
    chk("rd_no_regrant", req_ready, 0);
    cyc();
    rdf_dout = D1;
    #1;
    chk("rd_beat1_valid", resp_valid, 4'b0100);
    chk("rd_beat1_data", resp_data, D1);
    cyc();
    #1;
    chk("rd_empty_drop", resp_valid, 0);

    // dcache write; beat1 held by wdf_full for three cycles.
    cyc();
    clr();
    set_req(1, 1'b0, 31'h2A0, {B1, B0}, 32'hABCD_1234);
    #1;
    chk("wr_ready", req_ready, 4'b0010);
    chk("wr_cmd", af_cmd_din, 3'b000);
    chk("wr_af_wr_en", af_wr_en, 1);
    chk("wr_addr", af_addr_din, 31'h2A0);
    chk("wr_beat0_en", wdf_wr_en, 1);
    chk("wr_beat0_data", wdf_din, B0);
    chk("wr_beat0_mask", wdf_mask_din, 16'h1234);
    cyc();
    clr();
    wdf_full = 1'b1;
    set_req(2, 1'b1, 31'h104, '0, '0);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("wr2_hold_en", wdf_wr_en, 0);
      chk("wr2_no_grant", req_ready, 0);
      chk("wr2_no_af", af_wr_en, 0);
      cyc();
    end
    wdf_full = 1'b0;
    #1;
    chk("wr_beat1_en", wdf_wr_en, 1);
    chk("wr_beat1_data", wdf_din, B1);
    chk("wr_beat1_mask", wdf_mask_din, 16'hABCD);
    chk("wr_beat1_no_grant", req_ready, 0);
    cyc();
    clr();

    // Address FIFO back-pressure blocks every grant.
    af_full = 1'b1;
    set_req(2, 1'b1, 31'h108, '0, '0);
    set_req(1, 1'b0, 31'h10C, {B1, B0}, '0);
    #1;
    chk("af_full_ready", req_ready, 0);
    chk("af_full_af_wr_en", af_wr_en, 0);
    chk("af_full_wdf", wdf_wr_en, 0);

    // Reset in the middle of WR2 drops beat1.
    cyc();
    clr();
    set_req(1, 1'b0, 31'h300, {B3, B2}, 32'hFFFF_0000);
    #1;
    chk("wr_b_ready", req_ready, 4'b0010);
    chk("wr_b_beat0", wdf_din, B2);
    cyc();
    clr();
    wdf_full  = 1'b1;
    rdf_valid = 1'b1;
    rdf_dout  = D1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wr2_wdf_en", wdf_wr_en, 0);
    chk("rst_wr2_wdf_din", wdf_din, 0);
    chk("rst_wr2_af", af_wr_en, 0);
    chk("rst_wr2_resp", resp_valid, 0);
    chk("rst_wr2_rdata", resp_data, 0);
    wdf_full = 1'b0;
    #1;
    chk("rst_wr2_unblocked", wdf_wr_en, 0);
    @(negedge clk);
    clr();
    rst_n = 1'b1;
    cyc();
    #1;
    chk("wr2_abandon", wdf_wr_en, 0);

    // All four requesters reading back to back from a reset pointer.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 31'h200 + 31'(i), '0, '0);
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("rr_grant%0d", g), req_ready, rr_exp[g]);
      cyc();
    end
    clr();
    rdf_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      rdf_dout = 128'(b);
      #1;
      chk($sformatf("rr_resp%0d", b), resp_valid, rr_exp[b/2]);
      cyc();
    end
    clr();

    // Fill the tag FIFO with gp reads; writes still pass; one return frees one slot.
    set_req(3, 1'b1, 31'h500, '0, '0);
    for (int n = 0; n < 8; n++) begin
      #1;
      chk($sformatf("fill_grant%0d", n), req_ready, 4'b1000);
      cyc();
    end
    #1;
    chk("tag_full_block", req_ready, 0);
    set_req(1, 1'b0, 31'h400, {B5, B4}, 32'h0);
    #1;
    chk("tag_full_wr_ready", req_ready, 4'b0010);
    chk("tag_full_wr_cmd", af_cmd_din, 3'b000);
    cyc();
    req_valid[1] = 1'b0;
    #1;
    chk("tag_full_wr_beat1", wdf_din, B5);
    chk("tag_full_wr_en", wdf_wr_en, 1);
    cyc();
    rdf_valid = 1'b1;
    rdf_dout  = D0;
    #1;
    chk("full_ret0_valid", resp_valid, 4'b1000);
    chk("full_ret0_block", req_ready, 0);
    cyc();
    rdf_dout = D1;
    #1;
    chk("full_ret1_valid", resp_valid, 4'b1000);
    chk("full_ret1_block", req_ready, 0);
    cyc();
    rdf_valid = 1'b0;
    #1;
    chk("full_resume", req_ready, 4'b1000);
    cyc();
    #1;
    chk("full_again", req_ready, 0);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Port `clk`: input, 1 bit, the cpu_clk_g domain; all state SHALL update on the rising edge.
REQ-003 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `req_valid`: input, 4 bits; one bit per requester: 0=video, 1=dcache, 2=icache, 3=gp.
REQ-005 Port `req_ready`: output, 4 bits; one-hot acceptance pulse per requester.
REQ-006 Port `req_rnw`: input, 4 bits; 1=read, 0=write, per requester.
REQ-007 Port `req_addr`: input, 124 bits; packed 4x31, requester i at [31i+30:31i].
REQ-008 Port `req_wdata`: input, 1024 bits; packed 4x256 burst data, beat0 in the low 128 bits.
REQ-009 Port `req_wmask`: input, 128 bits; packed 4x32 byte masks, 1=byte masked.
REQ-010 Port `af_wr_en`: output, 1 bit; DDR2 address FIFO push.
REQ-011 Port `af_addr_din`: output, 31 bits; address FIFO address.
REQ-012 Port `af_cmd_din`: output, 3 bits; address FIFO command, 3'b001=read, 3'b000=write.
REQ-013 Port `af_full`: input, 1 bit; address FIFO full.
REQ-014 Port `wdf_wr_en`: output, 1 bit; write-data FIFO push.
REQ-015 Port `wdf_din`: output, 128 bits; write-data FIFO data.
REQ-016 Port `wdf_mask_din`: output, 16 bits; write-data FIFO byte mask.
REQ-017 Port `wdf_full`: input, 1 bit; write-data FIFO full.
REQ-018 Port `rdf_valid`: input, 1 bit; read-data beat valid.
REQ-019 Port `rdf_dout`: input, 128 bits; read-data beat.
REQ-020 Port `resp_valid`: output, 4 bits; one-hot read-beat delivery.
REQ-021 Port `resp_data`: output, 128 bits; read-beat data shared by all requesters.

Function
REQ-022 FSM states SHALL be IDLE and WR2; a grant SHALL be made only in IDLE.
REQ-023 In IDLE the block SHALL grant at most one eligible requester per cycle, where eligible means: req_valid=1, !af_full, and either (read and the tag FIFO is not full) or (write and !wdf_full).
REQ-024 Arbitration SHALL be round-robin over eligible requesters, starting from the requester after the last grant; the pointer resets to 0.
REQ-025 On a grant the block SHALL, in the same cycle, assert req_ready[i], af_wr_en, af_addr_din=addr_i, af_cmd_din=cmd, all combinationally from IDLE state.
REQ-026 On a read grant the block SHALL push tag i into an 8-entry tag FIFO and remain in IDLE.
REQ-027 On a write grant the block SHALL push beat0 and mask[15:0] to the WDF, latch beat1 and mask[31:16], and enter WR2.
REQ-028 In WR2 the block SHALL assert wdf_wr_en with the latched beat1 when !wdf_full and return to IDLE; otherwise it SHALL hold. No grant SHALL occur in WR2.
REQ-029 Each rdf_valid beat SHALL be forwarded combinationally as resp_valid[tag_head]=1, resp_data=rdf_dout.
REQ-030 A beat counter SHALL pop the tag FIFO after every second beat.
REQ-031 A tag push and pop in the same cycle SHALL leave the occupancy unchanged; a push while full SHALL be impossible by REQ-023.
REQ-032 A rdf_valid while the tag FIFO is empty is a protocol error; resp_valid SHALL stay 0 and the tag FIFO state SHALL not change.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE, the round-robin pointer 0, the tag FIFO empty, and the beat counter 0.
REQ-034 While rst_n=0, all outputs SHALL be 0.
REQ-035 A reset mid-WR2 SHALL abandon beat1.

Configuration
REQ-036 With VIDEO_PRIORITY_EN defined, an eligible requester 0 SHALL always win and SHALL not advance the round-robin pointer.
REQ-037 Without VIDEO_PRIORITY_EN, requester 0 SHALL participate in plain round-robin.

Verification
REQ-038 Read grant: a single read from icache at addr 0x100 -> af_cmd_din=001 and req_ready=0100 in the same cycle; 2 rdf beats -> resp_valid=0100 twice, then the tag FIFO is empty.
REQ-039 Write sequence: a dcache write -> cycle N: af_wr_en=1 and wdf beat0; cycle N+1: wdf beat1; with wdf_full held 3 cycles in WR2, beat1 is issued on the first cycle wdf_full=0.
REQ-040 Round-robin: all 4 requesters reading continuously, macro off -> grant order 0,1,2,3,0; with the macro on -> requester 0 granted every cycle.
REQ-041 Tag FIFO full: 8 reads outstanding -> read grants stop while writes still proceed; one 2-beat return -> one read grant resumes.
REQ-042 Back-pressure and reset: af_full=1 -> no grant and req_ready=0; asserting rst_n=0 in WR2 -> all outputs 0 and IDLE after release.
